// File: rtl/lfsr_ctrl_if.sv
// Bundles the host-side job handshake and the LFSR-side drive/observe
// signals of lfsr_ctrl.
interface lfsr_ctrl_if #(
   parameter int N      = 4,
   parameter int STEP_W = 8
);
   logic              start;
   logic              mode;
   logic [N-1:0]      seed_in;
   logic [STEP_W-1:0] steps;
   logic              abort;
   logic [N-1:0]      lfsr_w;
   logic              lfsr_sel;
   logic [N-1:0]      lfsr_seed;
   logic              busy;
   logic              done;
   logic              err;
   logic [N-1:0]      result;
   logic [4:0]        period;

   // The controller is the slave; a host or bench (also modelling the LFSR) is the master.
   modport slave (
      input  start, mode, seed_in, steps, abort, lfsr_w,
      output lfsr_sel, lfsr_seed, busy, done, err, result, period
   );

   modport master (
      output start, mode, seed_in, steps, abort, lfsr_w,
      input  lfsr_sel, lfsr_seed, busy, done, err, result, period
   );
endinterface

// File: rtl/lfsr_ctrl.sv
// Sequencer for a 4-bit LFSR: runs a fixed number of shifts (step mode)
// or measures the cycle length back to the seed (period mode).
module lfsr_ctrl #(
   parameter int N       = 4,
   parameter int STEP_W  = 8,
   parameter int TIMEOUT = 16
) (
   input logic        clk,
   input logic        rst,
   lfsr_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   localparam logic [STEP_W-1:0] TIMEOUT_CNT = STEP_W'(TIMEOUT);

   state_t            state;
   state_t            state_next;
   logic [STEP_W-1:0] cnt;
   logic [STEP_W-1:0] steps_reg;
   logic [N-1:0]      seed_reg;
   logic [N-1:0]      result_reg;
   logic [4:0]        period_reg;
   logic              mode_reg;
   logic              done_reg;
   logic              err_reg;
   logic              accept;
   logic              zero_seed;
   logic              finish;
   logic              time_out;
   logic              cnt_inc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Abort outranks completion; a period match at the timeout count still counts as a match.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      zero_seed  = 1'b0;
      finish     = 1'b0;
      time_out   = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.seed_in != '0) begin
                  accept     = 1'b1;
                  state_next = LOAD;
               end else begin
                  zero_seed = 1'b1;
               end
            end
         end
         LOAD: begin
            state_next = bus.abort ? IDLE : RUN;
         end
         RUN: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else if (!mode_reg) begin
               if (cnt == steps_reg) finish  = 1'b1;
               else                  cnt_inc = 1'b1;
            end else if (cnt != '0 && bus.lfsr_w == seed_reg) begin
               finish = 1'b1;
            end else if (cnt == TIMEOUT_CNT) begin
               time_out = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
            if (finish || time_out) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         steps_reg  <= '0;
         seed_reg   <= '0;
         mode_reg   <= 1'b0;
         result_reg <= '0;
         period_reg <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         done_reg <= finish;
         err_reg  <= zero_seed | time_out;
         if (accept) begin
            seed_reg  <= bus.seed_in;
            mode_reg  <= bus.mode;
            steps_reg <= bus.steps;
            cnt       <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
         end
         if (finish || time_out) begin
            result_reg <= bus.lfsr_w;
            period_reg <= (finish && mode_reg) ? cnt[4:0] : 5'd0;
         end
      end
   end

   assign bus.lfsr_sel  = (state == RUN);
   assign bus.lfsr_seed = seed_reg;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_reg;
   assign bus.err       = err_reg;
   assign bus.result    = result_reg;
   assign bus.period    = period_reg;
endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl with a behavioural maximal-length 4-bit LFSR
// (x^4 + x^3 + 1) hooked to the controller, plus a free-standing reference copy.
module tb_lfsr_ctrl;
   logic clk = 1'b0;
   logic rst;

   lfsr_ctrl_if #(.N(4), .STEP_W(8)) bus ();

   lfsr_ctrl #(.N(4), .STEP_W(8), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         err_count   = 0;
   int         check_count = 0;
   int         edges;
   int         done_seen;
   logic [3:0] lfsr_q      = 4'b0000;
   logic       force_en    = 1'b0;
   logic [3:0] force_val   = 4'b0000;
   logic [3:0] ref_q       = 4'b0000;
   logic       ref_sel     = 1'b0;
   logic [3:0] ref_seed    = 4'b0000;

   function automatic logic [3:0] lfsrNext(input logic [3:0] s);
      return {s[2:0], s[3] ^ s[2]};
   endfunction

   // The LFSR under control, with an override so a never-matching output can be forced.
   always @(posedge clk) lfsr_q <= bus.lfsr_sel ? lfsrNext(lfsr_q) : bus.lfsr_seed;
   assign bus.lfsr_w = force_en ? force_val : lfsr_q;

   always @(posedge clk) ref_q <= ref_sel ? lfsrNext(ref_q) : ref_seed;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents a job for one edge (E0) and returns #1 after it.
   task automatic applyStimulus(input logic m, input logic [3:0] seed, input logic [7:0] st);
      bus.start   = 1'b1;
      bus.mode    = m;
      bus.seed_in = seed;
      bus.steps   = st;
      @(posedge clk); #1;
      bus.start   = 1'b0;
   endtask

   task automatic waitJob(input int budget, output int n);
      n = 0;
      while (!(bus.done || bus.err) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("job_ends_in_budget", 32'(bus.done | bus.err), 32'd1);
   endtask

   initial begin
      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.mode    = 1'b0;
      bus.seed_in = 4'h0;
      bus.steps   = 8'd0;
      bus.abort   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy",   32'(bus.busy),      32'd0);
      checkOutput("rst_done",   32'(bus.done),      32'd0);
      checkOutput("rst_err",    32'(bus.err),       32'd0);
      checkOutput("rst_sel",    32'(bus.lfsr_sel),  32'd0);
      checkOutput("rst_seed",   32'(bus.lfsr_seed), 32'd0);
      checkOutput("rst_result", 32'(bus.result),    32'd0);
      checkOutput("rst_period", 32'(bus.period),    32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      applyStimulus(1'b0, 4'b0000, 8'd0);
      checkOutput("zero_err",      32'(bus.err),  32'd1);
      checkOutput("zero_busy",     32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      checkOutput("zero_err_drop", 32'(bus.err),  32'd0);
      checkOutput("zero_busy2",    32'(bus.busy), 32'd0);

      applyStimulus(1'b0, 4'b1111, 8'd0);
      checkOutput("s0_busy_load", 32'(bus.busy),     32'd1);
      checkOutput("s0_sel_load",  32'(bus.lfsr_sel), 32'd0);
      waitJob(10, edges);
      checkOutput("s0_latency", 32'(edges),      32'd2);
      checkOutput("s0_done",    32'(bus.done),   32'd1);
      checkOutput("s0_err",     32'(bus.err),    32'd0);
      checkOutput("s0_result",  32'(bus.result), 32'hF);
      checkOutput("s0_period",  32'(bus.period), 32'd0);
      @(posedge clk); #1;
      checkOutput("s0_done_pulse", 32'(bus.done), 32'd0);

      applyStimulus(1'b0, 4'b1111, 8'd3);
      waitJob(20, edges);
      checkOutput("s3_latency", 32'(edges),      32'd5);
      checkOutput("s3_done",    32'(bus.done),   32'd1);
      checkOutput("s3_result",  32'(bus.result), 32'b1000);

      ref_seed = 4'b1111;
      ref_sel  = 1'b0;
      @(posedge clk); #1;
      ref_sel  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ref_sel  = 1'b0;
      checkOutput("s3_ref_model", 32'(ref_q),      32'b1000);
      checkOutput("s3_vs_ref",    32'(bus.result), 32'(ref_q));

      applyStimulus(1'b1, 4'b1111, 8'd0);
      waitJob(40, edges);
      checkOutput("per_latency", 32'(edges),      32'd17);
      checkOutput("per_done",    32'(bus.done),   32'd1);
      checkOutput("per_period",  32'(bus.period), 32'd15);
      checkOutput("per_result",  32'(bus.result), 32'hF);

      force_en  = 1'b1;
      force_val = 4'b0101;
      applyStimulus(1'b1, 4'b1010, 8'd0);
      waitJob(40, edges);
      checkOutput("to_latency", 32'(edges),      32'd18);
      checkOutput("to_err",     32'(bus.err),    32'd1);
      checkOutput("to_done",    32'(bus.done),   32'd0);
      checkOutput("to_period",  32'(bus.period), 32'd0);
      checkOutput("to_result",  32'(bus.result), 32'b0101);
      force_en = 1'b0;
      @(posedge clk); #1;

      // Abort lands on the second RUN cycle (after E2); result must keep the timeout value.
      applyStimulus(1'b0, 4'b1111, 8'd10);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("ab_in_run", 32'(bus.lfsr_sel), 32'd1);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      checkOutput("ab_busy",   32'(bus.busy),   32'd0);
      checkOutput("ab_done",   32'(bus.done),   32'd0);
      checkOutput("ab_err",    32'(bus.err),    32'd0);
      checkOutput("ab_result", 32'(bus.result), 32'b0101);
      done_seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done || bus.err) done_seen++;
      end
      checkOutput("ab_no_late_done", 32'(done_seen), 32'd0);

      applyStimulus(1'b0, 4'b1111, 8'd10);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_busy",   32'(bus.busy),      32'd0);
      checkOutput("mid_rst_sel",    32'(bus.lfsr_sel),  32'd0);
      checkOutput("mid_rst_seed",   32'(bus.lfsr_seed), 32'd0);
      checkOutput("mid_rst_result", 32'(bus.result),    32'd0);
      #2;
      rst = 1'b1;
      done_seen = 0;
      repeat (14) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) done_seen++;
      end
      checkOutput("post_rst_quiet", 32'(done_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end
endmodule

// File: doc/lfsr_ctrl.md
# lfsr_ctrl

Sequencer for the team's 4-bit `lfsr` block: accepts a seed and a job over a start pulse, drives the LFSR's `sel`/`seed` inputs, and watches its output `w`. It supports two jobs. Step mode runs the LFSR a given number of shifts and returns the final state. Period mode counts shifts until the state returns to the seed. It sits between a host or test harness and one `lfsr` instance, so software never toggles `sel` directly.

## Interface
- `N`, 4, LFSR width.
- `STEP_W`, 8, width of the step count and the internal shift counter.
- `TIMEOUT`, 16 (2^N), shift count at which period mode gives up.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  job request, sampled in IDLE only.
- `mode`  in  1  job type, sampled with `start`: 0 = step, 1 = period.
- `seed_in`  in  N  seed, sampled with `start`.
- `steps`  in  STEP_W  number of shifts for step mode, sampled with `start`.
- `abort`  in  1  cancels the job in LOAD/RUN.
- `lfsr_w`  in  N  LFSR output.
- `lfsr_sel`  out  1  to LFSR `sel`: 0 = load seed, 1 = shift.
- `lfsr_seed`  out  N  to LFSR `seed`, equal to the latched seed register.
- `busy`  out  1  high while the state is not IDLE.
- `done`  out  1  one-cycle pulse when a job completes.
- `err`  out  1  one-cycle pulse on zero seed or period timeout.
- `result`  out  N  LFSR state at completion, held until the next completion.
- `period`  out  5  measured period (0 on timeout or in step mode), held until the next completion.

## Operation
- States:
  - IDLE: `lfsr_sel`=0.
  - LOAD: `lfsr_sel`=0; the LFSR loads `lfsr_seed` at the next edge.
  - RUN: `lfsr_sel`=1; the counter `cnt` counts shifts performed, and during a RUN cycle `lfsr_w` reflects `cnt` shifts.
- IDLE → LOAD: `start`=1 and `seed_in`≠0. This edge latches seed, mode and steps, and sets `cnt`←0.
- IDLE, `start`=1 and `seed_in`=0: `err` pulses the next cycle; stay in IDLE. All-zero is the LFSR lock-up state.
- LOAD → RUN unconditionally; `cnt`=0 in the first RUN cycle.
- RUN, step mode: the job is terminal when `cnt`==steps.
- RUN, period mode:
  - Terminal when `cnt`≠0 and `lfsr_w`==seed.
  - Timeout when `cnt`==TIMEOUT with no match.
- On a terminal edge:
  - `result`←`lfsr_w`.
  - `period`←`cnt` in period mode, 0 in step mode.
  - `done`←1; go to IDLE.
- On a timeout edge: `result`←`lfsr_w`, `period`←0, `err`←1, `done` stays 0; go to IDLE.
- Non-terminal RUN edge: `cnt`←`cnt`+1.
  - In period mode, `cnt` never exceeds TIMEOUT.
  - In step mode, `cnt` never exceeds `steps`, so the counter does not wrap.
- The LFSR also shifts on the terminal edge (`lfsr_sel`=1). This is harmless: the value was already captured, and IDLE reloads the seed.
- `abort` in LOAD or RUN: go to IDLE at the next edge. No `done`, no `err`; `result`/`period` unchanged. `abort` in IDLE is ignored.
- `abort` and terminal condition in the same cycle: `abort` wins, no `done`.
- `start` while busy is ignored. Latched operands do not change mid-job.

## Timing
- Reset (`rst` low, asynchronous): state IDLE; `cnt`, seed reg, `result`, `period` = 0; `done`=`err`=`busy`=`lfsr_sel`=0; `lfsr_seed`=0.
- Reset mid-job drops the job immediately; no `done`.
- Edge labels:
  - E0 is the edge that samples `start`.
  - E1 is LOAD → RUN; the LFSR holds the seed after E1.
- Step mode:
  - Terminal edge is E(steps+2).
  - `done` is high in the cycle after E(steps+2).
  - `busy` is high from after E0 through E(steps+2).
  - `steps`=0: `result`=seed, `done` high after E2.
- Period mode, period P: `done` is high after E(P+2) with `period`=P.
- Period mode, timeout: `err` is high after E(TIMEOUT+2).
- Zero seed: `err` is high in the cycle after E0; `busy` stays 0.
- Back-to-back jobs: `start` held high is accepted again in the first IDLE cycle, the same cycle `done` is high.

## Test plan
- Reset: drop `rst` to 0 mid-RUN, asynchronously between edges. All outputs go to 0 immediately; after release, `busy`=0 and no `done`.
- Step mode: `seed_in`=1111, `steps`=0, with the team's `lfsr`. Expect `done` one cycle after E2, `result`=1111, `period`=0, `lfsr_sel` low during LOAD.
- Step mode: `seed_in`=1111, `steps`=3. Expect `result` equal to the `lfsr` output 3 shifts after the seed, with `done` after E5. Cross-check by running the LFSR directly with `sel`=1 for 3 cycles.
- Period mode: `seed_in`=1111, maximal-length 4-bit `lfsr`. Expect `period`=15, `result`=1111, `done` after E17.
- Period timeout: bench model holds `lfsr_w`=0101, `seed_in`=1010. Expect `err` after E18, `done`=0, `period`=0, `result`=0101.
- Zero seed and abort:
  - `seed_in`=0000: expect an `err` pulse and `busy` staying 0.
  - Separately, `abort` on the 2nd RUN cycle of a `steps`=10 job: expect IDLE, no `done`/`err`, previous `result` retained.
